// File: rtl/halt_watchdog_pkg.sv
// Shared types and constants for the halt watchdog: FSM state encoding and default run budget.
package halt_watchdog_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_HALTED  = 2'd2,
        ST_TIMEOUT = 2'd3
    } wd_state_e;

    localparam int unsigned TIMEOUT_CYCLES_DEF = 32'd100000;
    localparam int unsigned CNT_W_DEF          = 32'd32;
    localparam int unsigned HCNT_W_DEF         = 32'd8;

endpackage

// File: rtl/halt_watchdog_if.sv
// Control and status bundle between the core controller (master) and the halt watchdog (slave).
interface halt_watchdog_if #(
    parameter int unsigned CNT_W  = 32,
    parameter int unsigned HCNT_W = 8
) ();
    logic              halt_act;
    logic              enable;
    logic              clear;
    logic [1:0]        state;
    logic              done;
    logic              timed_out;
    logic [CNT_W-1:0]  cycle_cnt;
    logic [HCNT_W-1:0] halt_cnt;

    modport master (
        output halt_act, enable, clear,
        input  state, done, timed_out, cycle_cnt, halt_cnt
    );

    modport slave (
        input  halt_act, enable, clear,
        output state, done, timed_out, cycle_cnt, halt_cnt
    );
endinterface

// File: rtl/halt_watchdog_edge_det.sv
// Rising-edge detector for halt_act; the delayed copy resets low so a high input right after reset is an edge.
module halt_edge_det (
    input  logic CLK,
    input  logic RST,
    input  logic in,
    output logic edge_o
);
    logic halt_q_r;

    // Track the previous level of the input every cycle regardless of FSM state.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            halt_q_r <= 1'b0;
        end else begin
            halt_q_r <= in;
        end
    end

    assign edge_o = in & ~halt_q_r;
endmodule

// File: rtl/halt_watchdog.sv
// Supervises one run of the halt unit: ends in HALTED on a halt edge or TIMEOUT after the cycle budget.
module halt_watchdog
    import halt_watchdog_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int unsigned CNT_W          = CNT_W_DEF,
    parameter int unsigned HCNT_W         = HCNT_W_DEF
) (
    input logic           CLK,
    input logic           RST,
    halt_watchdog_if.slave bus
);
    localparam logic [CNT_W-1:0]  CNT_MAX     = '1;
    localparam logic [HCNT_W-1:0] HCNT_MAX    = '1;
    localparam logic [CNT_W-1:0]  TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);

    wd_state_e         state_r;
    logic              done_r;
    logic              timed_out_r;
    logic [CNT_W-1:0]  cycle_cnt_r;
    logic [HCNT_W-1:0] halt_cnt_r;
    logic [CNT_W-1:0]  cnt_inc_s;
    logic [HCNT_W-1:0] hcnt_inc_s;
    logic              halt_edge_s;

    halt_edge_det u_edge_det (
        .CLK    (CLK),
        .RST    (RST),
        .in     (bus.halt_act),
        .edge_o (halt_edge_s)
    );

    // Saturating next values for both counters.
    always_comb begin
        cnt_inc_s  = cycle_cnt_r;
        hcnt_inc_s = halt_cnt_r;
        if (cycle_cnt_r != CNT_MAX) begin
            cnt_inc_s = cycle_cnt_r + CNT_W'(1);
        end else begin
            cnt_inc_s = cycle_cnt_r;
        end
        if (halt_cnt_r != HCNT_MAX) begin
            hcnt_inc_s = halt_cnt_r + HCNT_W'(1);
        end else begin
            hcnt_inc_s = halt_cnt_r;
        end
    end

    // Watchdog FSM with its registered status flags and counters; clear overrides every state.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r     <= ST_IDLE;
            done_r      <= 1'b0;
            timed_out_r <= 1'b0;
            cycle_cnt_r <= '0;
            halt_cnt_r  <= '0;
        end else if (bus.clear) begin
            state_r     <= ST_IDLE;
            done_r      <= 1'b0;
            timed_out_r <= 1'b0;
            cycle_cnt_r <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    cycle_cnt_r <= '0;
                    if (bus.enable) begin
                        state_r <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // A halt edge beats a coincident timeout.
                    if (halt_edge_s) begin
                        state_r     <= ST_HALTED;
                        done_r      <= 1'b1;
                        cycle_cnt_r <= cnt_inc_s;
                        halt_cnt_r  <= hcnt_inc_s;
                    end else if (cycle_cnt_r >= TIMEOUT_VAL) begin
                        state_r     <= ST_TIMEOUT;
                        timed_out_r <= 1'b1;
                    end else begin
                        cycle_cnt_r <= cnt_inc_s;
                    end
                end
                ST_HALTED, ST_TIMEOUT: begin
                    state_r <= state_r;
                end
                default: begin
                    state_r     <= ST_IDLE;
                    done_r      <= 1'b0;
                    timed_out_r <= 1'b0;
                    cycle_cnt_r <= '0;
                end
            endcase
        end
    end

    assign bus.state     = state_r;
    assign bus.done      = done_r;
    assign bus.timed_out = timed_out_r;
    assign bus.cycle_cnt = cycle_cnt_r;
    assign bus.halt_cnt  = halt_cnt_r;
endmodule

// File: tb/tb_halt_watchdog.sv
// Directed self-checking bench for halt_watchdog with a 16-cycle run budget.
module tb_halt_watchdog;
    logic CLK;
    logic RST;
    int   checks;
    int   failures;

    halt_watchdog_if #(.CNT_W(32), .HCNT_W(8)) bus ();

    halt_watchdog #(
        .TIMEOUT_CYCLES (16),
        .CNT_W          (32),
        .HCNT_W         (8)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic chk_all(input string tag, input logic [1:0] st, input logic dn, input logic to,
                           input logic [31:0] cc, input logic [7:0] hc);
        chk({tag, ".state"}, 64'(bus.state), 64'(st));
        chk({tag, ".done"}, 64'(bus.done), 64'(dn));
        chk({tag, ".timed_out"}, 64'(bus.timed_out), 64'(to));
        chk({tag, ".cycle_cnt"}, 64'(bus.cycle_cnt), 64'(cc));
        chk({tag, ".halt_cnt"}, 64'(bus.halt_cnt), 64'(hc));
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        RST          = 1'b1;
        bus.halt_act = 1'b0;
        bus.enable   = 1'b0;
        bus.clear    = 1'b0;
        #3;
        chk_all("reset", 2'd0, 1'b0, 1'b0, 32'd0, 8'd0);
        step(2);
        RST = 1'b0;
        step(1);
        chk_all("post_reset_idle", 2'd0, 1'b0, 1'b0, 32'd0, 8'd0);

        // Scenario 1: halt edge seen while cycle_cnt=9 freezes it at 10.
        bus.enable = 1'b1;
        step(1);
        bus.enable = 1'b0;
        chk_all("s1_run_entry", 2'd1, 1'b0, 1'b0, 32'd0, 8'd0);
        step(9);
        chk("s1_cnt9", 64'(bus.cycle_cnt), 64'd9);
        bus.halt_act = 1'b1;
        step(1);
        chk_all("s1_halted", 2'd2, 1'b1, 1'b0, 32'd10, 8'd1);
        step(3);
        chk_all("s1_hold", 2'd2, 1'b1, 1'b0, 32'd10, 8'd1);

        // Scenario 6: clear wins over enable, then enable alone restarts; halt_act still high.
        bus.clear  = 1'b1;
        bus.enable = 1'b1;
        step(1);
        chk_all("s6_idle", 2'd0, 1'b0, 1'b0, 32'd0, 8'd1);
        bus.clear = 1'b0;
        step(1);
        bus.enable = 1'b0;
        chk_all("s6_run", 2'd1, 1'b0, 1'b0, 32'd0, 8'd1);
        step(2);
        chk_all("s6_level_no_edge", 2'd1, 1'b0, 1'b0, 32'd2, 8'd1);
        bus.halt_act = 1'b0;

        // Scenario 2: no halt, timeout one edge after cycle_cnt reaches 16.
        step(14);
        chk_all("s2_cnt16", 2'd1, 1'b0, 1'b0, 32'd16, 8'd1);
        step(1);
        chk_all("s2_timeout", 2'd3, 1'b0, 1'b1, 32'd16, 8'd1);
        step(2);
        chk_all("s2_hold", 2'd3, 1'b0, 1'b1, 32'd16, 8'd1);
        bus.clear = 1'b1;
        step(1);
        bus.clear = 1'b0;
        chk_all("s2_clear", 2'd0, 1'b0, 1'b0, 32'd0, 8'd1);

        // Scenario 3: halt edge in the cycle cycle_cnt=16 -> HALTED, never TIMEOUT.
        bus.enable = 1'b1;
        step(1);
        bus.enable = 1'b0;
        step(16);
        chk_all("s3_cnt16", 2'd1, 1'b0, 1'b0, 32'd16, 8'd1);
        bus.halt_act = 1'b1;
        step(1);
        chk_all("s3_halted", 2'd2, 1'b1, 1'b0, 32'd17, 8'd2);

        // Scenario 4: level held across clear/enable counts only after a fall and rise.
        bus.clear = 1'b1;
        step(1);
        bus.clear  = 1'b0;
        bus.enable = 1'b1;
        step(1);
        bus.enable = 1'b0;
        step(3);
        chk_all("s4_held_run", 2'd1, 1'b0, 1'b0, 32'd3, 8'd2);
        bus.clear = 1'b1;
        step(1);
        bus.clear  = 1'b0;
        bus.enable = 1'b1;
        step(1);
        bus.enable = 1'b0;
        step(2);
        chk_all("s4_reenable", 2'd1, 1'b0, 1'b0, 32'd2, 8'd2);
        bus.halt_act = 1'b0;
        step(1);
        chk("s4_fall_run", 64'(bus.state), 64'd1);
        bus.halt_act = 1'b1;
        step(1);
        chk_all("s4_rise_halted", 2'd2, 1'b1, 1'b0, 32'd4, 8'd3);
        step(2);
        chk("s4_once", 64'(bus.halt_cnt), 64'd3);

        // Clear with a coincident halt edge in RUN aborts without counting.
        bus.clear = 1'b1;
        step(1);
        bus.clear  = 1'b0;
        bus.enable = 1'b1;
        bus.halt_act = 1'b0;
        step(1);
        bus.enable = 1'b0;
        step(1);
        bus.halt_act = 1'b1;
        bus.clear    = 1'b1;
        step(1);
        bus.clear = 1'b0;
        chk_all("abort_edge_dropped", 2'd0, 1'b0, 1'b0, 32'd0, 8'd3);

        // Halt edges in IDLE are ignored.
        bus.halt_act = 1'b0;
        step(1);
        bus.halt_act = 1'b1;
        step(1);
        chk_all("idle_edge_ignored", 2'd0, 1'b0, 1'b0, 32'd0, 8'd3);

        // Scenario 5: asynchronous reset mid-RUN at cycle_cnt=7.
        bus.halt_act = 1'b0;
        bus.enable   = 1'b1;
        step(1);
        bus.enable = 1'b0;
        step(7);
        chk_all("s5_cnt7", 2'd1, 1'b0, 1'b0, 32'd7, 8'd3);
        #2;
        RST = 1'b1;
        #1;
        chk_all("s5_async_reset", 2'd0, 1'b0, 1'b0, 32'd0, 8'd0);
        step(1);
        RST = 1'b0;
        step(2);
        chk_all("s5_wait_idle", 2'd0, 1'b0, 1'b0, 32'd0, 8'd0);
        bus.enable = 1'b1;
        step(1);
        bus.enable = 1'b0;
        chk("s5_rerun", 64'(bus.state), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
